// File: rtl/axis_cplx_equalizer.sv
// axis_cplx_equalizer
//
// One-tap complex equalizer for a multi-lane AXI-Stream IQ bus. Every lane of
// every beat is multiplied by one shared complex coefficient, then rounded
// half-up and saturated back to DATA_W bits. New coefficients go into a shadow
// register. The shadow value becomes active only when a tlast beat is accepted,
// so one frame always uses a single coefficient.
//
// Pipeline: p1 = input and active coefficient, p2 = partial products,
// m_axis_* = combined, rounded and saturated output.
//
// Ports:
//   s_axis_aclk / s_axis_areset      clock, synchronous active-high reset
//   s_axis_tdata/tid/tuser/tlast/tvalid/tready   input stream
//                                    (lane k: I at [2k*DATA_W +: DATA_W],
//                                     Q at [(2k+1)*DATA_W +: DATA_W])
//   m_axis_tdata/tid/tuser/tlast/tvalid/tready   equalized output stream
//   coef_wdata {Q, I} / coef_wvalid  write into the coefficient shadow register
//   coef_pending                     the shadow holds a value not yet applied
//   frame_cnt                        accepted tlast beats, wraps at 16 bits
//   sat_cnt                          only when EQ_SAT_CNT_EN is defined: sticky
//                                    count of saturated output components
//
// Optional feature macro: EQ_SAT_CNT_EN
module axis_cplx_equalizer #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int ID_W      = 8,
  parameter int USER_W    = 8
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_areset,
  input  logic [NUM_LANES*2*DATA_W-1:0] s_axis_tdata,
  input  logic [ID_W-1:0]               s_axis_tid,
  input  logic [USER_W-1:0]             s_axis_tuser,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [NUM_LANES*2*DATA_W-1:0] m_axis_tdata,
  output logic [ID_W-1:0]               m_axis_tid,
  output logic [USER_W-1:0]             m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  input  logic [2*COEF_W-1:0]           coef_wdata,
  input  logic                          coef_wvalid,
  output logic                          coef_pending,
  output logic [15:0]                   frame_cnt
`ifdef EQ_SAT_CNT_EN
  ,
  output logic [15:0]                   sat_cnt
`endif
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 1;
  localparam int BUS_W  = NUM_LANES * 2 * DATA_W;
  localparam int SB_W   = ID_W + USER_W + 1;

  localparam logic signed [COEF_W-1:0] C_ONE = COEF_W'(1 << COEF_FRAC);
  localparam logic signed [ACC_W-1:0]  RND   = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0]  Y_MAX =
    $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0]  Y_MIN = ~Y_MAX;

  function automatic logic signed [ACC_W-1:0] round_shr(input logic signed [ACC_W-1:0] acc);
    round_shr = (acc + RND) >>> COEF_FRAC;
  endfunction

  function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
    sat_hit = (v > Y_MAX) || (v < Y_MIN);
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > Y_MAX)
      saturate = Y_MAX[DATA_W-1:0];
    else if (v < Y_MIN)
      saturate = Y_MIN[DATA_W-1:0];
    else
      saturate = v[DATA_W-1:0];
  endfunction

  typedef enum logic {C_IDLE, C_PEND} cstate_t;

  logic    clk;
  logic    rst;
  logic    en;
  logic    accept;
  logic    swap;
  cstate_t cstate;

  logic signed [COEF_W-1:0] coef_act_i, coef_act_q;
  logic signed [COEF_W-1:0] coef_sh_i, coef_sh_q;

  logic signed [DATA_W-1:0] xi_p1 [NUM_LANES];
  logic signed [DATA_W-1:0] xq_p1 [NUM_LANES];
  logic signed [COEF_W-1:0] ci_p1, cq_p1;
  logic [SB_W-1:0]          sb_p1;
  logic                     vld_p1;

  logic signed [PROD_W-1:0] pii_p2 [NUM_LANES];
  logic signed [PROD_W-1:0] pqq_p2 [NUM_LANES];
  logic signed [PROD_W-1:0] piq_p2 [NUM_LANES];
  logic signed [PROD_W-1:0] pqi_p2 [NUM_LANES];
  logic [SB_W-1:0]          sb_p2;
  logic                     vld_p2;

  logic [BUS_W-1:0]         y_bus;

  assign clk           = s_axis_aclk;
  assign rst           = s_axis_areset;
  assign en            = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = en && !rst;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign swap          = accept && s_axis_tlast;
  assign coef_pending  = (cstate == C_PEND);

`ifdef EQ_SAT_CNT_EN
  localparam int SC_W = $clog2(2*NUM_LANES + 1);
  logic [2*NUM_LANES-1:0] sat_flags;
  logic [SC_W-1:0]        sat_sum;
  logic [16:0]            sat_next;
`endif

  // Control: coefficient shadow/active swap, frame count, stage valids, output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cstate        <= C_IDLE;
      coef_act_i    <= C_ONE;
      coef_act_q    <= '0;
      coef_sh_i     <= C_ONE;
      coef_sh_q     <= '0;
      frame_cnt     <= '0;
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (coef_wvalid) begin
        coef_sh_i <= $signed(coef_wdata[COEF_W-1:0]);
        coef_sh_q <= $signed(coef_wdata[2*COEF_W-1:COEF_W]);
      end
      if (swap) begin
        coef_act_i <= coef_sh_i;
        coef_act_q <= coef_sh_q;
        frame_cnt  <= frame_cnt + 16'd1;
      end
      case (cstate)
        C_IDLE: if (coef_wvalid) cstate <= C_PEND;
        C_PEND: if (swap && !coef_wvalid) cstate <= C_IDLE;
        default: cstate <= C_IDLE;
      endcase
      if (en) begin
        vld_p1        <= accept;
        vld_p2        <= vld_p1;
        m_axis_tvalid <= vld_p2;
        if (vld_p2) begin
          m_axis_tdata                          <= y_bus;
          {m_axis_tid, m_axis_tuser, m_axis_tlast} <= sb_p2;
        end
      end
    end
  end

  // Stage p1 -> p2: input capture with the coefficient in force, then products.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        xi_p1[k]  <= $signed(s_axis_tdata[2*k*DATA_W +: DATA_W]);
        xq_p1[k]  <= $signed(s_axis_tdata[(2*k+1)*DATA_W +: DATA_W]);
        pii_p2[k] <= PROD_W'(xi_p1[k]) * PROD_W'(ci_p1);
        pqq_p2[k] <= PROD_W'(xq_p1[k]) * PROD_W'(cq_p1);
        piq_p2[k] <= PROD_W'(xi_p1[k]) * PROD_W'(cq_p1);
        pqi_p2[k] <= PROD_W'(xq_p1[k]) * PROD_W'(ci_p1);
      end
      ci_p1 <= coef_act_i;
      cq_p1 <= coef_act_q;
      sb_p1 <= {s_axis_tid, s_axis_tuser, s_axis_tlast};
      sb_p2 <= sb_p1;
    end
  end

  // Stage p2 -> output: full-precision add/sub, round half up, saturate.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic signed [ACC_W-1:0] acc_i, acc_q, rnd_i, rnd_q;
    assign acc_i = $signed({pii_p2[k][PROD_W-1], pii_p2[k]}) - $signed({pqq_p2[k][PROD_W-1], pqq_p2[k]});
    assign acc_q = $signed({piq_p2[k][PROD_W-1], piq_p2[k]}) + $signed({pqi_p2[k][PROD_W-1], pqi_p2[k]});
    assign rnd_i = round_shr(acc_i);
    assign rnd_q = round_shr(acc_q);
    assign y_bus[2*k*DATA_W +: DATA_W]     = saturate(rnd_i);
    assign y_bus[(2*k+1)*DATA_W +: DATA_W] = saturate(rnd_q);
`ifdef EQ_SAT_CNT_EN
    assign sat_flags[2*k]   = sat_hit(rnd_i);
    assign sat_flags[2*k+1] = sat_hit(rnd_q);
`endif
  end

`ifdef EQ_SAT_CNT_EN
  always_comb begin
    sat_sum = '0;
    for (int k = 0; k < 2*NUM_LANES; k++)
      sat_sum = sat_sum + SC_W'(sat_flags[k]);
  end

  assign sat_next = {1'b0, sat_cnt} + 17'(sat_sum);

  always_ff @(posedge clk) begin
    if (rst)
      sat_cnt <= '0;
    else if (en && vld_p2)
      sat_cnt <= sat_next[16] ? 16'hFFFF : sat_next[15:0];
  end
`endif

endmodule

// File: tb/tb_axis_cplx_equalizer.sv
// Directed, table-driven bench for axis_cplx_equalizer (default parameters).
module tb_axis_cplx_equalizer;

  localparam int NL = 4;
  localparam int DW = 16;
  localparam int BW = NL * 2 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] s_tdata;
  logic [7:0]    s_tid, s_tuser;
  logic          s_tlast, s_tvalid, s_tready;
  logic [BW-1:0] m_tdata;
  logic [7:0]    m_tid, m_tuser;
  logic          m_tlast, m_tvalid, m_tready;
  logic [31:0]   coef_wdata;
  logic          coef_wvalid, coef_pending;
  logic [15:0]   frame_cnt;
`ifdef EQ_SAT_CNT_EN
  logic [15:0]   sat_cnt;
`endif

  always #5 clk = ~clk;

  axis_cplx_equalizer dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tid    (s_tid),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tid    (m_tid),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .coef_wdata    (coef_wdata),
    .coef_wvalid   (coef_wvalid),
    .coef_pending  (coef_pending),
    .frame_cnt     (frame_cnt)
`ifdef EQ_SAT_CNT_EN
    ,
    .sat_cnt       (sat_cnt)
`endif
  );

  typedef struct {
    logic [BW-1:0] data;
    logic [7:0]    id;
    logic [7:0]    user;
    logic          last;
  } beat_t;

  typedef struct {
    int ci, cq;
    int xi0, xq0, xi1, xq1;
    int yi0, yq0, yi1, yq1;
    int nsat;
  } vec_t;

  beat_t exp_q[$];
  beat_t out_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    exp_fc = 0;
  int    exp_sat = 0;

  always @(posedge clk) begin
    if (!rst && m_tvalid && m_tready)
      out_q.push_back('{data: m_tdata, id: m_tid, user: m_tuser, last: m_tlast});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_bus(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Lanes 2 and 3 repeat lanes 0 and 1.
  function automatic logic [BW-1:0] mk_bus(input int i0, input int q0, input int i1, input int q1);
    logic [BW-1:0] b;
    b[15:0]   = 16'(i0);
    b[31:16]  = 16'(q0);
    b[47:32]  = 16'(i1);
    b[63:48]  = 16'(q1);
    b[127:64] = b[63:0];
    return b;
  endfunction

  function automatic logic [BW-1:0] ramp_bus(input int i);
    logic [BW-1:0] b;
    for (int k = 0; k < NL; k++) begin
      b[2*k*DW +: DW]     = 16'(i*100 + k);
      b[(2*k+1)*DW +: DW] = 16'(-(i*100 + k));
    end
    return b;
  endfunction

  task automatic expect_beat(input logic [BW-1:0] d, input logic [7:0] id,
                             input logic [7:0] user, input logic last);
    exp_q.push_back('{data: d, id: id, user: user, last: last});
  endtask

  // Call just after a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [BW-1:0] d, input logic [7:0] id,
                      input logic [7:0] user, input logic last);
    int t;
    t = 0;
    s_tdata  = d;
    s_tid    = id;
    s_tuser  = user;
    s_tlast  = last;
    s_tvalid = 1'b1;
    forever begin
      @(posedge clk);
      if (s_tready) break;
      t++;
      if (t > 100) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: got no accept, expected accept within 100 cycles");
        break;
      end
    end
    if (last) exp_fc++;
    @(negedge clk);
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic write_coef(input int ci, input int cq);
    coef_wdata  = {16'(cq), 16'(ci)};
    coef_wvalid = 1'b1;
    @(negedge clk);
    coef_wvalid = 1'b0;
  endtask

  task automatic drain();
    int    t;
    beat_t e, a;
    t = 0;
    while (out_q.size() < exp_q.size() && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("beat_count", out_q.size(), exp_q.size());
    while (exp_q.size() > 0 && out_q.size() > 0) begin
      e = exp_q.pop_front();
      a = out_q.pop_front();
      chk_bus("out_data", a.data, e.data);
      chk("out_sideband", int'({a.id, a.user, a.last}), int'({e.id, e.user, e.last}));
    end
    exp_q.delete();
    out_q.delete();
  endtask

  vec_t vecs[7];

  initial begin
    int            k;
    logic [BW-1:0] b1000;

    vecs[0] = '{16384, 0,      1000, -2000,   -1, 1,          1000, -2000,   -1, 1,      0};
    vecs[1] = '{0, 16384,      1000, -2000,    3, -7,         2000, 1000,     7, 3,      0};
    vecs[2] = '{32767, 0,      30000, 0,   -30000, 0,         32767, 0,  -32768, 0,      4};
    vecs[3] = '{8192, 0,       3, -3,       1000, 0,          2, -1,        500, 0,      0};
    vecs[4] = '{16384, 16384,  100, 50,   -32768, -32768,     50, 150,        0, -32768, 2};
    vecs[5] = '{-16384, 0,     -32768, 5,      7, -32768,     32767, -5,     -7, 32767,  4};
    vecs[6] = '{-32768, -32768, -32768, -32768, 1, 0,         0, 32767,      -2, -2,     2};

    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tid = '0; s_tuser = '0; s_tlast = 1'b0;
    m_tready = 1'b1; coef_wvalid = 1'b0; coef_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_s_tready", int'(s_tready), 0);
    chk("rst_m_tvalid", int'(m_tvalid), 0);
    chk_bus("rst_m_tdata", m_tdata, '0);
    chk("rst_pending", int'(coef_pending), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_tready", int'(s_tready), 1);

    // Latency and sideband at unity gain
    expect_beat(mk_bus(1000, -2000, 5, -6), 8'h11, 8'hA5, 1'b1);
    send(mk_bus(1000, -2000, 5, -6), 8'h11, 8'hA5, 1'b1);
    idle();
    k = 0;
    while (!m_tvalid && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("latency_edges", k + 1, 3);
    chk_bus("latency_data", m_tdata, mk_bus(1000, -2000, 5, -6));
    drain();

    // Coefficient table: write, swap with an all-zero tlast beat, then one test beat
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      write_coef(vecs[i].ci, vecs[i].cq);
      chk("pend_set", int'(coef_pending), 1);
      expect_beat('0, 8'(i), 8'h00, 1'b1);
      send('0, 8'(i), 8'h00, 1'b1);
      chk("pend_clr", int'(coef_pending), 0);
      expect_beat(mk_bus(vecs[i].yi0, vecs[i].yq0, vecs[i].yi1, vecs[i].yq1), 8'(i + 32), 8'(i + 64), 1'b0);
      send(mk_bus(vecs[i].xi0, vecs[i].xq0, vecs[i].xi1, vecs[i].xq1), 8'(i + 32), 8'(i + 64), 1'b0);
      idle();
      drain();
      exp_sat += vecs[i].nsat;
`ifdef EQ_SAT_CNT_EN
      chk("sat_cnt", int'(sat_cnt), exp_sat);
`endif
    end

    // Back to unity
    write_coef(16384, 0);
    expect_beat('0, 8'h00, 8'h00, 1'b1);
    send('0, 8'h00, 8'h00, 1'b1);
    idle();
    drain();

    // 20-beat ramp with a 5-cycle output stall
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (i == 8) begin
        idle();
        m_tready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_s_tready", int'(s_tready), 0);
          chk("stall_m_tvalid", int'(m_tvalid), 1);
          chk_bus("stall_m_tdata", m_tdata, ramp_bus(5));
        end
        m_tready = 1'b1;
      end
      expect_beat(ramp_bus(i), 8'(i), ~8'(i), i == 19);
      send(ramp_bus(i), 8'(i), ~8'(i), i == 19);
    end
    idle();
    drain();
    chk("frame_cnt_ramp", int'(frame_cnt), exp_fc);

    // 4-beat frame, coefficient written during beat 2
    b1000 = mk_bus(1000, 0, 1000, 0);
    for (int b = 1; b <= 4; b++) begin
      if (b == 2) begin
        coef_wdata  = {16'd0, 16'd8192};
        coef_wvalid = 1'b1;
      end
      expect_beat(b1000, 8'(b), 8'h00, b == 4);
      send(b1000, 8'(b), 8'h00, b == 4);
      coef_wvalid = 1'b0;
      if (b == 2) chk("frame_pend_set", int'(coef_pending), 1);
      if (b == 3) chk("frame_pend_hold", int'(coef_pending), 1);
    end
    chk("frame_pend_clr", int'(coef_pending), 0);
    expect_beat(mk_bus(500, 0, 500, 0), 8'h05, 8'h00, 1'b0);
    send(b1000, 8'h05, 8'h00, 1'b0);
    idle();
    @(negedge clk);
    chk("frame_cnt_inc", int'(frame_cnt), exp_fc);
    drain();

    // Write coinciding with a tlast acceptance keeps the write pending
    coef_wdata  = {16'd0, 16'd16384};
    coef_wvalid = 1'b1;
    expect_beat('0, 8'h06, 8'h00, 1'b1);
    send('0, 8'h06, 8'h00, 1'b1);
    coef_wvalid = 1'b0;
    chk("coincide_pend", int'(coef_pending), 1);
    expect_beat(mk_bus(500, 0, 500, 0), 8'h07, 8'h00, 1'b1);
    send(b1000, 8'h07, 8'h00, 1'b1);
    chk("coincide_pend_clr", int'(coef_pending), 0);
    expect_beat(b1000, 8'h08, 8'h00, 1'b0);
    send(b1000, 8'h08, 8'h00, 1'b0);
    idle();
    drain();

    // Reset mid-frame with a pending coefficient and beats in flight
    m_tready = 1'b0;
    write_coef(8192, 0);
    chk("midrst_pend_set", int'(coef_pending), 1);
    send(b1000, 8'h09, 8'h00, 1'b0);
    send(b1000, 8'h0A, 8'h00, 1'b0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_m_tvalid", int'(m_tvalid), 0);
    chk("midrst_pending", int'(coef_pending), 0);
    chk("midrst_frame_cnt", int'(frame_cnt), 0);
    chk_bus("midrst_m_tdata", m_tdata, '0);
    chk("midrst_s_tready", int'(s_tready), 0);
`ifdef EQ_SAT_CNT_EN
    chk("midrst_sat_cnt", int'(sat_cnt), 0);
`endif
    rst = 1'b0;
    exp_fc = 0;
    out_q.delete();
    exp_q.delete();
    m_tready = 1'b1;
    #1;
    chk("midrst_ready_after", int'(s_tready), 1);
    expect_beat(mk_bus(1000, -2000, 1000, -2000), 8'h0B, 8'h3C, 1'b1);
    send(mk_bus(1000, -2000, 1000, -2000), 8'h0B, 8'h3C, 1'b1);
    expect_beat(b1000, 8'h0C, 8'h00, 1'b0);
    send(b1000, 8'h0C, 8'h00, 1'b0);
    idle();
    drain();
    chk("midrst_frame_cnt_after", int'(frame_cnt), exp_fc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
